// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the packet buffer memory controllers.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        CLEAR
    } rd_state_t;

    localparam int RD_LAT       = 1;
    localparam int RD_BUF_DEPTH = 2;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry output FIFO holding {data, sop, eop} between memory read data and the stream port.
module rd_skid_buf
    import mem_ctrl_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              push_sop,
    input  logic              push_eop,
    input  logic              pop,
    output logic [1:0]        occ,
    output logic              empty,
    output logic [DWIDTH-1:0] head_data,
    output logic              head_sop,
    output logic              head_eop
);

    logic [DWIDTH-1:0] data_q [RD_BUF_DEPTH];
    logic              sop_q  [RD_BUF_DEPTH];
    logic              eop_q  [RD_BUF_DEPTH];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage carries no reset; the control side qualifies it with occupancy.
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_q[wr_ptr] <= push_data;
            sop_q[wr_ptr]  <= push_sop;
            eop_q[wr_ptr]  <= push_eop;
        end
    end

    assign occ       = count;
    assign empty     = (count == 2'd0);
    assign head_data = data_q[rd_ptr];
    assign head_sop  = sop_q[rd_ptr];
    assign head_eop  = eop_q[rd_ptr];

endmodule

// File: rtl/mem_rd_ctrl.sv
// Packet buffer read controller: streams stored words with sop/eop, then pulses clr_o.
// Optional MEM_RD_CTRL_DROP_EN adds drop_i to discard a packet without reading it.
module mem_rd_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              busy_i,
    input  logic [AWIDTH-1:0] wraddr_i,
    input  logic [DWIDTH-1:0] rddata_i,
    input  logic              ready_i,
`ifdef MEM_RD_CTRL_DROP_EN
    input  logic              drop_i,
`endif
    output logic              rden_o,
    output logic [AWIDTH-1:0] rdaddr_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              val_o,
    output logic              sop_o,
    output logic              eop_o,
    output logic              clr_o
);

    localparam logic [AWIDTH:0] CNT_ONE  = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic [AWIDTH:0] FULL_LEN = {1'b1, {AWIDTH{1'b0}}};

    rd_state_t         state;
    logic [AWIDTH:0]   len;
    logic [AWIDTH:0]   rd_cnt;
    logic              vld_p1;
    logic              sop_p1;
    logic              eop_p1;
    logic [1:0]        occ;
    logic              empty;
    logic [DWIDTH-1:0] head_data;
    logic              head_sop;
    logic              head_eop;
    logic              pop;
    logic              issue;
    logic              last_rd;
    logic              drop;
    logic [2:0]        pending;

`ifdef MEM_RD_CTRL_DROP_EN
    assign drop = drop_i;
`else
    assign drop = 1'b0;
`endif

    assign pop     = ~empty & ready_i;
    // Words that will occupy the buffer after this edge; keeps at most two buffered.
    assign pending = {1'b0, occ} + {2'b0, vld_p1} - {2'b0, pop};
    assign issue   = (state == READ) && (pending < 3'(RD_BUF_DEPTH));
    assign last_rd = (rd_cnt == len - CNT_ONE);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state  <= IDLE;
            len    <= '0;
            rd_cnt <= '0;
            vld_p1 <= 1'b0;
            sop_p1 <= 1'b0;
            eop_p1 <= 1'b0;
            clr_o  <= 1'b0;
        end else begin
            // Read issue -> memory data valid (one cycle of read latency)
            vld_p1 <= issue;
            sop_p1 <= issue && (rd_cnt == '0);
            eop_p1 <= issue && last_rd;
            clr_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (busy_i) begin
                        if (drop) begin
                            state <= CLEAR;
                            clr_o <= 1'b1;
                        end else begin
                            len    <= (wraddr_i == '0) ? FULL_LEN : {1'b0, wraddr_i};
                            rd_cnt <= '0;
                            state  <= READ;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        if (last_rd) state <= DRAIN;
                        else         rd_cnt <= rd_cnt + CNT_ONE;
                    end
                end
                DRAIN: begin
                    if (pop && head_eop) begin
                        state <= CLEAR;
                        clr_o <= 1'b1;
                    end
                end
                CLEAR: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    rd_skid_buf #(
        .DWIDTH (DWIDTH)
    ) u_skid (
        .clk_i     (clk_i),
        .arstn_i   (arstn_i),
        .push      (vld_p1),
        .push_data (rddata_i),
        .push_sop  (sop_p1),
        .push_eop  (eop_p1),
        .pop       (pop),
        .occ       (occ),
        .empty     (empty),
        .head_data (head_data),
        .head_sop  (head_sop),
        .head_eop  (head_eop)
    );

    assign rden_o   = issue;
    assign rdaddr_o = rd_cnt[AWIDTH-1:0];
    assign val_o    = ~empty;
    assign data_o   = empty ? '0 : head_data;
    assign sop_o    = ~empty & head_sop;
    assign eop_o    = ~empty & head_eop;

endmodule
